// File: rtl/mainram_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mainram_pkg
// Shared types and helpers for the main work RAM bus controller.
//   size_e  : access size encoding as seen on the request ports
//   state_e : controller FSM states
//   owner_e : which requester currently holds the grant
//   byteena_of(size, addr_lo) : RAM byte enables for an access
//   beats_of(size)            : number of 16-bit bus beats for an access
// ---------------------------------------------------------------------------
package mainram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Size code 3 falls into the default arm and behaves as a word.
    function automatic logic [3:0] byteena_of(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // The external bus is 16 bits wide, so only full words need two beats.
    function automatic int beats_of(input logic [1:0] size);
        return ((size == SZ_BYTE) || (size == SZ_HALF)) ? 1 : 2;
    endfunction

endpackage

// File: rtl/mainram_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mainram_bus_ctrl_if
// Bundles the CPU request port, the DMA request port and the RAM array port.
//   master : the environment (CPU, DMA engine and RAM array)
//   slave  : the bus controller
// Parameter RAM_AW sets the RAM word-address width.
// ---------------------------------------------------------------------------
interface mainram_bus_ctrl_if #(
    parameter int RAM_AW = 14
);
    logic              cpu_req;
    logic              cpu_rnw;
    logic [1:0]        cpu_size;
    logic [23:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;

    logic              dma_req;
    logic              dma_rnw;
    logic [1:0]        dma_size;
    logic [23:0]       dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ack;
    logic [31:0]       dma_rdata;

    logic              ram_wren;
    logic [31:0]       ram_data;
    logic [3:0]        ram_byteena;
    logic [RAM_AW-1:0] ram_address;
    logic [31:0]       ram_q;

    modport master (
        output cpu_req, cpu_rnw, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_rnw, dma_size, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_wren, ram_data, ram_byteena, ram_address,
        output ram_q
    );

    modport slave (
        input  cpu_req, cpu_rnw, cpu_size, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_rnw, dma_size, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_wren, ram_data, ram_byteena, ram_address,
        input  ram_q
    );
endinterface

// File: rtl/mainram_bus_ctrl_lane_align.sv
// ---------------------------------------------------------------------------
// mainram_lane_align
// Purely combinational lane handling between a requester and the 32-bit RAM.
//   i_size, i_addr_lo : access size and byte offset within the word
//   i_wdata           : right-justified write data
//   i_ram_q           : raw RAM word
//   o_wdata_rep       : write data replicated onto every lane
//   o_byteena         : byte enables for the access
//   o_rdata           : read data extracted (byte/half, zero-extended) or
//                       rotated (word, misaligned ARM LDR semantics)
// ---------------------------------------------------------------------------
module mainram_lane_align
    import mainram_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_ram_q,
    output logic [31:0] o_wdata_rep,
    output logic [3:0]  o_byteena,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_lane [4];
    logic [15:0] w_half;
    logic [31:0] w_rot;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = i_ram_q[8*gi +: 8];
    end

    always_comb begin
        o_byteena   = byteena_of(i_size, i_addr_lo);
        o_wdata_rep = i_wdata;
        case (i_size)
            SZ_BYTE: o_wdata_rep = {4{i_wdata[7:0]}};
            SZ_HALF: o_wdata_rep = {2{i_wdata[15:0]}};
            default: o_wdata_rep = i_wdata;
        endcase
    end

    always_comb begin
        w_half = i_addr_lo[1] ? i_ram_q[31:16] : i_ram_q[15:0];
        // Rotate right by 8 x offset.
        w_rot  = i_ram_q;
        case (i_addr_lo)
            2'd1:    w_rot = {i_ram_q[7:0],  i_ram_q[31:8]};
            2'd2:    w_rot = {i_ram_q[15:0], i_ram_q[31:16]};
            2'd3:    w_rot = {i_ram_q[23:0], i_ram_q[31:24]};
            default: w_rot = i_ram_q;
        endcase
        case (i_size)
            SZ_BYTE: o_rdata = {24'h0, w_lane[i_addr_lo]};
            SZ_HALF: o_rdata = {16'h0, w_half};
            default: o_rdata = w_rot;
        endcase
    end
endmodule

// File: rtl/mainram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mainram_bus_ctrl
// Bus-side front end for the 16K x 32 main work RAM. Arbitrates CPU and DMA
// (DMA has fixed priority), inserts EWRAM wait states (word = two 16-bit
// beats), steers write lanes and aligns read data.
//   clock    : sole clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : slave side of mainram_bus_ctrl_if (CPU, DMA and RAM ports)
// Optional macro MAINRAM_PERF_EN adds:
//   perf_wait_cycles : cycles spent in WAIT (wraps)
//   perf_conflicts   : IDLE cycles with both requests high (wraps)
// ---------------------------------------------------------------------------
module mainram_bus_ctrl
    import mainram_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int RAM_AW      = 14
) (
    input  logic               clock,
    input  logic               reset_n,
    mainram_bus_ctrl_if.slave  bus
`ifdef MAINRAM_PERF_EN
    ,
    output logic [31:0]        perf_wait_cycles,
    output logic [31:0]        perf_conflicts
`endif
);
    localparam int MAX_N = 2 * (WAIT_STATES + 1);
    localparam int CNT_W = $clog2(MAX_N + 1);

    state_e            r_state;
    owner_e            r_owner;
    logic              r_rnw;
    logic [1:0]        r_size;
    logic [RAM_AW+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_dma_rdata;
    logic              r_ram_wren;
    logic [31:0]       r_ram_data;
    logic [3:0]        r_ram_byteena;
    logic [RAM_AW-1:0] r_ram_address;

    logic              w_any_req;
    logic              w_in_rnw;
    logic [1:0]        w_in_size;
    logic [RAM_AW+1:0] w_in_addr;
    logic [31:0]       w_in_wdata;
    logic [CNT_W-1:0]  w_in_load;
    logic              w_sel_rnw;
    logic [1:0]        w_sel_size;
    logic [RAM_AW+1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_enter_access;
    logic [31:0]       w_wdata_rep;
    logic [3:0]        w_byteena;
    logic [31:0]       w_rdata;
    logic              w_unused_addr_hi;

    // Address bits above the RAM window are mirrors and deliberately dropped.
    assign w_unused_addr_hi = ^{bus.cpu_addr[23:RAM_AW+2], bus.dma_addr[23:RAM_AW+2]};

    // Arbitration: DMA wins whenever it is requesting.
    always_comb begin
        w_any_req  = bus.cpu_req | bus.dma_req;
        w_in_rnw   = bus.dma_req ? bus.dma_rnw   : bus.cpu_rnw;
        w_in_size  = bus.dma_req ? bus.dma_size  : bus.cpu_size;
        w_in_addr  = bus.dma_req ? bus.dma_addr[RAM_AW+1:0] : bus.cpu_addr[RAM_AW+1:0];
        w_in_wdata = bus.dma_req ? bus.dma_wdata : bus.cpu_wdata;
        w_in_load  = CNT_W'((WAIT_STATES + 1) * beats_of(w_in_size) - 1);
    end

    // In IDLE the incoming request feeds the lane logic directly so that a
    // zero-wait access can go straight to ACCESS; otherwise use the latch.
    always_comb begin
        w_sel_rnw   = (r_state == ST_IDLE) ? w_in_rnw   : r_rnw;
        w_sel_size  = (r_state == ST_IDLE) ? w_in_size  : r_size;
        w_sel_addr  = (r_state == ST_IDLE) ? w_in_addr  : r_addr;
        w_sel_wdata = (r_state == ST_IDLE) ? w_in_wdata : r_wdata;
        w_enter_access = ((r_state == ST_IDLE) && w_any_req && (w_in_load == '0)) ||
                         ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));
    end

    mainram_lane_align u_lane_align (
        .i_size      (w_sel_size),
        .i_addr_lo   (w_sel_addr[1:0]),
        .i_wdata     (w_sel_wdata),
        .i_ram_q     (bus.ram_q),
        .o_wdata_rep (w_wdata_rep),
        .o_byteena   (w_byteena),
        .o_rdata     (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_CPU;
            r_rnw         <= 1'b1;
            r_size        <= 2'd0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_cpu_ack     <= 1'b0;
            r_dma_ack     <= 1'b0;
            r_cpu_rdata   <= '0;
            r_dma_rdata   <= '0;
            r_ram_wren    <= 1'b0;
            r_ram_data    <= '0;
            r_ram_byteena <= '0;
            r_ram_address <= '0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_ram_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= bus.dma_req ? OWN_DMA : OWN_CPU;
                        r_rnw   <= w_in_rnw;
                        r_size  <= w_in_size;
                        r_addr  <= w_in_addr;
                        r_wdata <= w_in_wdata;
                        r_cnt   <= w_in_load;
                        r_state <= (w_in_load == '0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // ram_q reflects ram_address during this cycle.
                    if (r_owner == OWN_DMA) begin
                        r_dma_rdata <= w_rdata;
                        r_dma_ack   <= 1'b1;
                    end else begin
                        r_cpu_rdata <= w_rdata;
                        r_cpu_ack   <= 1'b1;
                    end
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // RAM port registers load on the edge into ACCESS and then hold.
            if (w_enter_access) begin
                r_ram_wren    <= ~w_sel_rnw;
                r_ram_data    <= w_wdata_rep;
                r_ram_byteena <= w_byteena;
                r_ram_address <= w_sel_addr[RAM_AW+1:2];
            end
        end
    end

    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.dma_ack     = r_dma_ack;
    assign bus.dma_rdata   = r_dma_rdata;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.ram_data    = r_ram_data;
    assign bus.ram_byteena = r_ram_byteena;
    assign bus.ram_address = r_ram_address;

`ifdef MAINRAM_PERF_EN
    logic [31:0] r_perf_wait;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_wait <= '0;
            r_perf_conf <= '0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
            if ((r_state == ST_IDLE) && bus.cpu_req && bus.dma_req) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_wait_cycles = r_perf_wait;
    assign perf_conflicts   = r_perf_conf;
`endif
endmodule

// File: tb/tb_mainram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mainram_bus_ctrl
// Directed bench for mainram_bus_ctrl with WAIT_STATES=2 (N=3 for byte/half,
// N=6 for word). Cycle 0 is the IDLE cycle whose closing edge samples the
// request; ACCESS is cycle N and the ack is cycle N+1. Outputs are sampled
// on the falling edge. Build with MAINRAM_PERF_EN to also check the counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mainram_bus_ctrl;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mainram_bus_ctrl_if #(.RAM_AW(14)) bus ();

`ifdef MAINRAM_PERF_EN
    logic [31:0] perf_wait_cycles;
    logic [31:0] perf_conflicts;
`endif

    mainram_bus_ctrl #(.WAIT_STATES(2), .RAM_AW(14)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MAINRAM_PERF_EN
        ,
        .perf_wait_cycles (perf_wait_cycles),
        .perf_conflicts   (perf_conflicts)
`endif
    );

    // Stand-alone lane aligner.
    logic [1:0]  la_size;
    logic [1:0]  la_lo;
    logic [31:0] la_wdata;
    logic [31:0] la_q;
    logic [31:0] la_rep;
    logic [3:0]  la_be;
    logic [31:0] la_rd;

    mainram_lane_align u_la (
        .i_size      (la_size),
        .i_addr_lo   (la_lo),
        .i_wdata     (la_wdata),
        .i_ram_q     (la_q),
        .o_wdata_rep (la_rep),
        .o_byteena   (la_be),
        .o_rdata     (la_rd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic dma, input logic v, input logic rnw,
                           input logic [1:0] sz, input logic [23:0] a, input logic [31:0] wd);
        if (dma) begin
            bus.dma_req = v; bus.dma_rnw = rnw; bus.dma_size = sz;
            bus.dma_addr = a; bus.dma_wdata = wd;
        end else begin
            bus.cpu_req = v; bus.cpu_rnw = rnw; bus.cpu_size = sz;
            bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
    endtask

    typedef struct {
        logic        dma;
        logic        rnw;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] ramq;
        int          n;
        logic [13:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_data;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    typedef struct {
        logic [1:0]  size;
        logic [1:0]  lo;
        logic [31:0] wdata;
        logic [31:0] q;
        logic [31:0] e_rep;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
    } la_vec_t;

    la_vec_t la_vecs [4];

    task automatic run_vec(input int idx, input vec_t v);
        logic        own_ack;
        logic        other_ack;
        logic        stray_wren;
        logic        wren_n;
        logic [13:0] addr_n;
        logic [3:0]  be_n;
        logic [31:0] data_n;
        logic [31:0] rd;
        int          ack_k;
        logic        ack_after;
        other_ack = 1'b0; stray_wren = 1'b0; wren_n = 1'b0;
        addr_n = '0; be_n = '0; data_n = '0; rd = '0; ack_k = 0;
        @(negedge clock);
        bus.ram_q = v.ramq;
        set_req(v.dma, 1'b1, v.rnw, v.size, v.addr, v.wdata);
        @(posedge clock);
        for (int k = 1; k <= 20 && ack_k == 0; k++) begin
            @(negedge clock);
            if (k == v.n) begin
                wren_n = bus.ram_wren; addr_n = bus.ram_address;
                be_n = bus.ram_byteena; data_n = bus.ram_data;
            end else if (bus.ram_wren) begin
                stray_wren = 1'b1;
            end
            own_ack = v.dma ? bus.dma_ack : bus.cpu_ack;
            if (v.dma ? bus.cpu_ack : bus.dma_ack) other_ack = 1'b1;
            if (own_ack) begin
                ack_k = k;
                rd = v.dma ? bus.dma_rdata : bus.cpu_rdata;
                set_req(v.dma, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
            end
        end
        if (ack_k == 0) set_req(v.dma, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
        @(negedge clock);
        ack_after = v.dma ? bus.dma_ack : bus.cpu_ack;
        chk($sformatf("v%0d ack_cycle", idx), 32'(ack_k), 32'(v.n + 1));
        chk($sformatf("v%0d ack_width", idx), {31'h0, ack_after}, 32'h0);
        chk($sformatf("v%0d other_ack", idx), {31'h0, other_ack}, 32'h0);
        chk($sformatf("v%0d wren", idx), {31'h0, wren_n}, {31'h0, ~v.rnw});
        chk($sformatf("v%0d stray_wren", idx), {31'h0, stray_wren}, 32'h0);
        chk($sformatf("v%0d ram_address", idx), {18'h0, addr_n}, {18'h0, v.e_addr});
        chk($sformatf("v%0d byteena", idx), {28'h0, be_n}, {28'h0, v.e_be});
        if (v.rnw) chk($sformatf("v%0d rdata", idx), rd, v.e_rdata);
        else       chk($sformatf("v%0d ram_data", idx), data_n, v.e_data);
        $display("txn %0d: %s %s size=%0d addr=%h ack@%0d rdata=%h data=%h be=%b",
                 idx, v.dma ? "DMA" : "CPU", v.rnw ? "rd" : "wr", v.size, v.addr, ack_k, rd, data_n, be_n);
    endtask

    // Both requesters raise together; returns the ack cycles seen.
    int race_dk, race_ck;
    logic race_c_at_dk;
`ifdef MAINRAM_PERF_EN
    logic [31:0] pw0, pc0, pw_dk, pc_dk;
`endif

    task automatic race(input logic [1:0] sz, input int e_dk);
        race_dk = 0; race_ck = 0; race_c_at_dk = 1'b0;
        @(negedge clock);
        bus.ram_q = 32'h0;
`ifdef MAINRAM_PERF_EN
        pw0 = perf_wait_cycles; pc0 = perf_conflicts;
        pw_dk = pw0; pc_dk = pc0;
`endif
        set_req(1'b1, 1'b1, 1'b1, sz, 24'h000008, 32'h0);
        set_req(1'b0, 1'b1, 1'b1, sz, 24'h00000C, 32'h0);
        @(posedge clock);
        for (int k = 1; k <= 40 && race_ck == 0; k++) begin
            @(negedge clock);
            if (k == e_dk) race_c_at_dk = bus.cpu_ack;
            if (bus.dma_ack && race_dk == 0) begin
                race_dk = k;
`ifdef MAINRAM_PERF_EN
                pw_dk = perf_wait_cycles; pc_dk = perf_conflicts;
`endif
                set_req(1'b1, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
            end
            if (bus.cpu_ack && race_ck == 0) begin
                race_ck = k;
                set_req(1'b0, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
            end
        end
        set_req(1'b1, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
        set_req(1'b0, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
        @(negedge clock);
        $display("race size=%0d: dma_ack@%0d cpu_ack@%0d", sz, race_dk, race_ck);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ram_wren"},    {31'h0, bus.ram_wren}, 32'h0);
        chk({tag, " ram_address"}, {18'h0, bus.ram_address}, 32'h0);
        chk({tag, " ram_byteena"}, {28'h0, bus.ram_byteena}, 32'h0);
        chk({tag, " ram_data"},    bus.ram_data, 32'h0);
        chk({tag, " acks"},        {30'h0, bus.cpu_ack, bus.dma_ack}, 32'h0);
        chk({tag, " cpu_rdata"},   bus.cpu_rdata, 32'h0);
        chk({tag, " dma_rdata"},   bus.dma_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs_wren, rs_ack;

        // dma rnw size addr wdata ramq n e_addr e_be e_data e_rdata
        vecs[0] = '{1'b0, 1'b0, 2'd0, 24'h000005, 32'h000000AB, 32'h0,        3, 14'h0001, 4'b0010, 32'hABABABAB, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 24'h00FFF1, 32'h0,        32'h11223344, 6, 14'h3FFC, 4'b1111, 32'h0, 32'h44112233};
        vecs[2] = '{1'b0, 1'b1, 2'd1, 24'h010002, 32'h0,        32'hBEEF1234, 3, 14'h0000, 4'b1100, 32'h0, 32'h0000BEEF};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 24'h000102, 32'h12345678, 32'h0,        3, 14'h0040, 4'b1100, 32'h56785678, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 24'h000007, 32'h0,        32'hA1B2C3D4, 3, 14'h0001, 4'b1000, 32'h0, 32'h000000A1};
        vecs[5] = '{1'b0, 1'b0, 2'd2, 24'h00ABCE, 32'hCAFEF00D, 32'h0,        6, 14'h2AF3, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 2'd2, 24'h000002, 32'h0,        32'h11223344, 6, 14'h0000, 4'b1111, 32'h0, 32'h33441122};
        vecs[7] = '{1'b0, 1'b1, 2'd0, 24'h000000, 32'h0,        32'h11223344, 3, 14'h0000, 4'b0001, 32'h0, 32'h00000044};
        vecs[8] = '{1'b0, 1'b0, 2'd1, 24'h000011, 32'h0000BEEF, 32'h0,        3, 14'h0004, 4'b0011, 32'hBEEFBEEF, 32'h0};
        vecs[9] = '{1'b0, 1'b1, 2'd3, 24'h000003, 32'h0,        32'h11223344, 6, 14'h0000, 4'b1111, 32'h0, 32'h22334411};

        // size lo wdata q e_rep e_be e_rd
        la_vecs[0] = '{2'd0, 2'd2, 32'h000000C3, 32'h11223344, 32'hC3C3C3C3, 4'b0100, 32'h00000022};
        la_vecs[1] = '{2'd1, 2'd3, 32'h0000A55A, 32'hCAFEBABE, 32'hA55AA55A, 4'b1100, 32'h0000CAFE};
        la_vecs[2] = '{2'd2, 2'd1, 32'h01234567, 32'hAABBCCDD, 32'h01234567, 4'b1111, 32'hDDAABBCC};
        la_vecs[3] = '{2'd3, 2'd3, 32'h89ABCDEF, 32'hAABBCCDD, 32'h89ABCDEF, 4'b1111, 32'hBBCCDDAA};

        set_req(1'b0, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
        bus.ram_q = 32'h0;
        la_size = 2'd0; la_lo = 2'd0; la_wdata = 32'h0; la_q = 32'h0;

        // Lane aligner alone.
        for (int i = 0; i < 4; i++) begin
            la_size = la_vecs[i].size; la_lo = la_vecs[i].lo;
            la_wdata = la_vecs[i].wdata; la_q = la_vecs[i].q;
            #1;
            chk($sformatf("la%0d wdata_rep", i), la_rep, la_vecs[i].e_rep);
            chk($sformatf("la%0d byteena", i), {28'h0, la_be}, {28'h0, la_vecs[i].e_be});
            chk($sformatf("la%0d rdata", i), la_rd, la_vecs[i].e_rd);
            $display("lane %0d: size=%0d lo=%0d rep=%h be=%b rd=%h", i, la_size, la_lo, la_rep, la_be, la_rd);
        end

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state("reset");
        reset_n = 1'b1;

        // Single-transaction vectors.
        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Simultaneous byte requests: DMA first, CPU after the next arbitration.
        race(2'd0, 4);
        chk("race dma_ack_cycle", 32'(race_dk), 32'd4);
        chk("race cpu_ack_cycle", 32'(race_ck), 32'd9);
        chk("race cpu_ack_at_4", {31'h0, race_c_at_dk}, 32'h0);

        // Simultaneous word requests.
        race(2'd2, 7);
        chk("race_w dma_ack_cycle", 32'(race_dk), 32'd7);
        chk("race_w cpu_ack_cycle", 32'(race_ck), 32'd15);
`ifdef MAINRAM_PERF_EN
        chk("perf wait after dma", pw_dk - pw0, 32'd5);
        chk("perf conflicts after dma", pc_dk - pc0, 32'd1);
        chk("perf wait after cpu", perf_wait_cycles - pw0, 32'd10);
        chk("perf conflicts after cpu", perf_conflicts - pc0, 32'd1);
`endif

        // Reset during WAIT of a word write: the write must be abandoned.
        rs_wren = 1'b0; rs_ack = 1'b0;
        @(negedge clock);
        set_req(1'b0, 1'b1, 1'b0, 2'd2, 24'h000040, 32'h12345678);
        @(posedge clock);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.ram_wren) rs_wren = 1'b1;
            if (bus.cpu_ack || bus.dma_ack) rs_ack = 1'b1;
            if (k == 2) begin
                reset_n = 1'b0;
                set_req(1'b0, 1'b0, 1'b1, 2'd0, 24'h0, 32'h0);
            end
            if (k == 3) chk_reset_state("midreset");
            if (k == 4) reset_n = 1'b1;
        end
        chk("midreset wren_seen", {31'h0, rs_wren}, 32'h0);
        chk("midreset ack_seen", {31'h0, rs_ack}, 32'h0);
        $display("midreset: wren_seen=%0b ack_seen=%0b", rs_wren, rs_ack);

        // A fresh request after reset completes on schedule.
        run_vec(10, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mainram_bus_ctrl.md
Name: mainram_bus_ctrl

Overview:
- Bus-side front end for the 16K x 32 main work RAM; sits directly upstream of the RAM array and drives its wren/data/byteena/address port.
- Arbitrates between a CPU port and a DMA port. DMA has fixed priority.
- Inserts EWRAM wait states: the external bus is 16-bit, so word accesses cost twice as much.
- Converts byte/halfword/word accesses into word-wide RAM cycles with byte enables, and aligns read data back to the requester.

Parameters:
- WAIT_STATES, 2, wait cycles per 16-bit bus beat (beat cost = WAIT_STATES+1 cycles).
- RAM_AW, 14, RAM word-address width (16384 words = 64 KB).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word).
- cpu_addr  in  24  byte address; bits above 15 ignored (64 KB mirror).
- cpu_wdata  in  32  write data, right-justified.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid only while cpu_ack is high.
- dma_req, dma_rnw, dma_size, dma_addr, dma_wdata, dma_ack, dma_rdata: same widths and meanings as the cpu_* ports.
- ram_wren  out  1  RAM write strobe.
- ram_data  out  32  RAM write data, lane-replicated.
- ram_byteena  out  4  byte enables.
- ram_address  out  RAM_AW  word address, equal to latched addr[15:2].
- ram_q  in  32  RAM read data; combinational from ram_address.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All acks and ram_wren go to 0; ram_data, ram_byteena, ram_address and both rdata outputs go to 0.
  - Reset mid-access abandons the access: no ack, no write.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If dma_req, latch the DMA request and set owner = DMA.
  - Else if cpu_req, latch the CPU request and set owner = CPU.
  - N = (WAIT_STATES+1) x (word ? 2 : 1). Load cnt = N-1.
  - If N-1 = 0, go to ACCESS; else go to WAIT.
- WAIT: cnt decrements each cycle. Leave for ACCESS on the cycle cnt = 1 is decremented to 0.
- ACCESS (exactly one cycle):
  - ram_address, ram_byteena and ram_data come from the latched request.
  - ram_wren = !rnw.
  - ram_q is aligned and registered into the owner's rdata.
- DONE (one cycle): owner's ack = 1 with rdata valid, then go to IDLE.
- Timing: with the request sampled in IDLE at cycle 0, ACCESS is cycle N and the ack is at cycle N+1. The next arbitration happens at cycle N+2.
- Non-owner ack stays 0. A grant is never preempted; a DMA request arriving mid-CPU access waits for IDLE.
- Simultaneous requests in IDLE: DMA wins and the CPU request stays pending. CPU starvation while DMA is continuously requesting is intended.
- Write lane steering:
  - byte: byteena = 1 << addr[1:0]; data = {4{wdata[7:0]}}.
  - half: byteena = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}; addr[0] ignored.
  - word: byteena = 4'b1111; data = wdata; addr[1:0] ignored.
- Read alignment:
  - byte: zero-extended ram_q byte addr[1:0].
  - half: zero-extended ram_q half addr[1].
  - word: ram_q rotated right by 8 x addr[1:0] (ARM misaligned LDR).
- Outside ACCESS: ram_wren = 0; ram_address and ram_byteena hold their last value.
- Requests that change while latched are ignored until the next IDLE.

Optional Feature:
- Macro: MAINRAM_PERF_EN.
- With it, two extra ports exist:
  - perf_wait_cycles  out  32: counts cycles spent in WAIT.
  - perf_conflicts  out  32: counts IDLE cycles where both requests are high.
  - Both reset to 0 and wrap modulo 2^32.
- Without it, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package mainram_pkg:
  - access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - owner enum;
  - functions byteena_of(size, addr[1:0]) and beats_of(size).
- Sub-module mainram_lane_align: purely combinational write-lane replication and read extract/rotate. Instanced once and unit-tested alone.

Test Plan (WAIT_STATES=2):
- CPU byte write, addr 0x000005, wdata 0xAB:
  - ACCESS at cycle 3 with ram_address=1, byteena=0010, data=0xABABABAB, ram_wren=1;
  - cpu_ack at cycle 4.
- CPU word read, addr 0x00FFF1, ram_q=0x11223344:
  - ram_address=0x3FFC;
  - cpu_ack at cycle 7 with cpu_rdata=0x44112233.
- Half read, addr 0x10002 (mirror), ram_q=0xBEEF1234:
  - ram_address=0; cpu_rdata=0x0000BEEF.
- cpu_req and dma_req rise together, both byte:
  - dma_ack at cycle 4; cpu_ack at cycle 9; cpu_ack stays low at cycle 4.
- reset_n low during WAIT of a write:
  - no ack, ram_wren never 1;
  - after release, a new request completes at N+1.
- MAINRAM_PERF_EN, one word access with both requests held:
  - perf_wait_cycles=5 after the DMA access; perf_conflicts increments per contested IDLE cycle.
